// File: rtl/risc_v_mc_core.sv
// rtl/risc_v_mc_core.sv - multicycle RV32I/RV32E subset core with a single shared memory port
module risc_v_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      pc,
    output logic             halted,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] retired
);

    localparam int AW = $clog2(NREGS);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [31:0] regs [NREGS];
    logic [31:0] ir, old_pc, a, b, imm, alu_out, mdr;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui, is_ebreak, legal;
    logic        use_rd, use_rs1, use_rs2, reg_bad;
    logic [31:0] imm_dec, rf_a, rf_b, opnd_b, alu_res, br_tgt, jalr_tgt, ls_addr;
    logic        taken, mis, xfer;
    logic [AW-1:0] rd_idx, rs1_idx, rs2_idx;

    assign opcode  = ir[6:0];
    assign f3      = ir[14:12];
    assign f7      = ir[31:25];
    assign rd_idx  = ir[7 +: AW];
    assign rs1_idx = ir[15 +: AW];
    assign rs2_idx = ir[20 +: AW];
    assign xfer    = mem_req & mem_ready;

    // Instruction classification and which register fields the format actually uses
    always_comb begin
        is_r = 1'b0; is_i = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_br = 1'b0;
        is_jal = 1'b0; is_jalr = 1'b0; is_lui = 1'b0; is_ebreak = 1'b0;
        use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        case (opcode)
            7'b0110011: begin
                is_r = ((f7 == 7'b0000000) && (f3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010, 3'b011}))
                    || ((f7 == 7'b0100000) && (f3 == 3'b000));
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b0010011: begin
                is_i = f3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            7'b0000011: begin
                is_lw = (f3 == 3'b010);
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            7'b0100011: begin
                is_sw = (f3 == 3'b010);
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b1100011: begin
                is_br = f3 inside {3'b000, 3'b001, 3'b100, 3'b101};
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            7'b1101111: begin
                is_jal = 1'b1;
                use_rd = 1'b1;
            end
            7'b1100111: begin
                is_jalr = (f3 == 3'b000);
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            7'b0110111: begin
                is_lui = 1'b1;
                use_rd = 1'b1;
            end
            7'b1110011: is_ebreak = (ir == 32'h0010_0073);
            default: ;
        endcase
    end

    assign legal   = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui;
    // Only RV32E has register fields that can fall outside the file
    assign reg_bad = (NREGS == 16) && ((use_rd && ir[11]) || (use_rs1 && ir[19]) || (use_rs2 && ir[24]));

    // Immediate generation for the I/S/B/U/J formats
    always_comb begin
        imm_dec = {{20{ir[31]}}, ir[31:20]};
        if (is_sw)
            imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        else if (is_br)
            imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        else if (is_lui)
            imm_dec = {ir[31:12], 12'b0};
        else if (is_jal)
            imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    end

    assign rf_a = (rs1_idx == '0) ? 32'h0 : regs[rs1_idx];
    assign rf_b = (rs2_idx == '0) ? 32'h0 : regs[rs2_idx];

    // ALU, branch compare and target/address arithmetic for the EXEC step
    always_comb begin
        opnd_b  = is_r ? b : imm;
        alu_res = 32'h0;
        case (f3)
            3'b000:  alu_res = (is_r && f7[5]) ? (a - opnd_b) : (a + opnd_b);
            3'b111:  alu_res = a & opnd_b;
            3'b110:  alu_res = a | opnd_b;
            3'b100:  alu_res = a ^ opnd_b;
            3'b010:  alu_res = {31'b0, ($signed(a) < $signed(opnd_b))};
            3'b011:  alu_res = {31'b0, (a < opnd_b)};
            default: alu_res = 32'h0;
        endcase
        if (is_lui)
            alu_res = imm;
        case (f3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) < $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            default: taken = 1'b0;
        endcase
        br_tgt   = old_pc + imm;
        jalr_tgt = (a + imm) & 32'hFFFF_FFFE;
        ls_addr  = a + imm;
        mis = (is_br && taken && (br_tgt[1:0] != 2'b00))
           || (is_jal && (br_tgt[1:0] != 2'b00))
           || (is_jalr && (jalr_tgt[1:0] != 2'b00))
           || ((is_lw || is_sw) && (ls_addr[1:0] != 2'b00));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (xfer) state_nx = S_DECODE;
            S_DECODE: begin
                if (is_ebreak || !legal || reg_bad) state_nx = S_HALT;
                else                                state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (mis)                 state_nx = S_HALT;
                else if (is_br)          state_nx = S_FETCH;
                else if (is_lw || is_sw) state_nx = S_MEM;
                else                     state_nx = S_WB;
            end
            S_MEM:    if (xfer) state_nx = is_lw ? S_WB : S_FETCH;
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_HALT;
        endcase
    end

    // Memory port and status outputs; requests are masked while reset is held
    always_comb begin
        mem_req   = rst && ((state == S_FETCH) || (state == S_MEM));
        mem_we    = rst && (state == S_MEM) && is_sw;
        mem_addr  = (state == S_MEM) ? alu_out : pc;
        mem_wdata = b;
        halted    = (state == S_HALT);
    end

    // Architectural state that reset defines: pc, halt cause, retire counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            err     <= 2'd0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: if (xfer) pc <= pc + 32'd4;
                S_DECODE: begin
                    if (is_ebreak)               err <= 2'd3;
                    else if (!legal || reg_bad)  err <= 2'd1;
                end
                S_EXEC: begin
                    if (mis)
                        err <= 2'd2;
                    else if (is_br) begin
                        if (taken) pc <= br_tgt;
                        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else if (is_jal)
                        pc <= br_tgt;
                    else if (is_jalr)
                        pc <= jalr_tgt;
                end
                S_MEM: if (xfer && is_sw) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
                S_WB:  retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
                default: ;
            endcase
        end
    end

    // Unreset datapath: instruction/operand latches and register-file write-back
    always_ff @(posedge clk) begin
        case (state)
            S_FETCH: if (xfer) begin
                ir     <= mem_rdata;
                old_pc <= pc;
            end
            S_DECODE: begin
                a   <= rf_a;
                b   <= rf_b;
                imm <= imm_dec;
            end
            S_EXEC: begin
                if (is_jal || is_jalr)   alu_out <= old_pc + 32'd4;
                else if (is_lw || is_sw) alu_out <= ls_addr;
                else                     alu_out <= alu_res;
            end
            S_MEM: if (xfer && is_lw) mdr <= mem_rdata;
            S_WB:  if (rd_idx != '0) regs[rd_idx] <= is_lw ? mdr : alu_out;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc_v_mc_core.sv
// tb/tb_risc_v_mc_core.sv - directed-program bench for risc_v_mc_core (RV32I and RV32E/4-bit counter instances)
module tb_risc_v_mc_core;

    logic        clk;
    logic        rst;

    logic        req_a, we_a, ready_a, halted_a;
    logic [31:0] addr_a, wdata_a, rdata_a, pc_a, retired_a;
    logic [1:0]  err_a;

    logic        req_b, we_b, ready_b, halted_b;
    logic [31:0] addr_b, wdata_b, rdata_b, pc_b;
    logic [1:0]  err_b;
    logic [3:0]  retired_b;

    logic [31:0] mem [2][64];
    int          wait_n [2];
    int          wcnt [2];
    logic [31:0] addr0, wdata0;
    logic        we0;
    int          unstable, ntx, nlog, step_bad;
    logic [31:0] flog [64];
    logic [31:0] prev_ret;

    int n_cmp = 0;
    int n_bad = 0;

    risc_v_mc_core dut_a (
        .clk(clk), .rst(rst),
        .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_ready(ready_a), .mem_rdata(rdata_a),
        .pc(pc_a), .halted(halted_a), .err(err_a), .retired(retired_a)
    );

    risc_v_mc_core #(.NREGS(16), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_ready(ready_b), .mem_rdata(rdata_b),
        .pc(pc_b), .halted(halted_b), .err(err_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_step(input int k, input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, inout logic ready, output logic [31:0] rdata);
        rdata = mem[k][addr[7:2]];
        if (!req) begin
            ready   = 1'b0;
            wcnt[k] = 0;
        end else begin
            if (ready) wcnt[k] = 0;
            if (k == 0) begin
                if (wcnt[0] == 0) begin
                    addr0 = addr; wdata0 = wdata; we0 = we;
                end else if (addr !== addr0 || wdata !== wdata0 || we !== we0) begin
                    unstable++;
                end
            end
            if (wcnt[k] >= wait_n[k]) begin
                ready = 1'b1;
                if (we) mem[k][addr[7:2]] = wdata;
                if (k == 0) begin
                    ntx++;
                    if (!we && nlog < 64) begin
                        flog[nlog] = addr;
                        nlog++;
                    end
                end
            end else begin
                ready = 1'b0;
                wcnt[k]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) prev_ret = 32'h0;
        else begin
            if (retired_a != prev_ret && retired_a != prev_ret + 32'd1) step_bad++;
            prev_ret = retired_a;
        end
        mem_step(0, req_a, we_a, addr_a, wdata_a, ready_a, rdata_a);
        mem_step(1, req_b, we_b, addr_b, wdata_b, ready_b, rdata_b);
    end

    task automatic hold();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[0][i] = 32'h0;
            mem[1][i] = 32'h0;
        end
        mem[1][0] = 32'h0000_0063;
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        nlog = 0; ntx = 0; unstable = 0;
        #2 rst = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ready_a = 1'b0; ready_b = 1'b0; rdata_a = 32'h0; rdata_b = 32'h0;
        wait_n[0] = 0; wait_n[1] = 0; wcnt[0] = 0; wcnt[1] = 0;
        unstable = 0; ntx = 0; nlog = 0; step_bad = 0; prev_ret = 32'h0;
        addr0 = 32'h0; wdata0 = 32'h0; we0 = 1'b0;

        // reset state
        hold();
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_halted", {31'b0, halted_a}, 32'h0);
        chk("rst_err", {30'b0, err_a}, 32'h0);
        chk("rst_retired", retired_a, 32'h0);
        chk("rst_req", {31'b0, req_a}, 32'h0);
        chk("rst_we", {31'b0, we_a}, 32'h0);

        // addi/addi/sub, zero wait; B runs a 3-cycle self loop to wrap its 4-bit counter
        hold();
        mem[0][0] = 32'h0050_0093;   // addi x1,x0,5
        mem[0][1] = 32'hFF90_8113;   // addi x2,x1,-7
        mem[0][2] = 32'h4020_81B3;   // sub  x3,x1,x2
        release_rst();
        tick(11);
        chk("alu_ret11", retired_a, 32'd2);
        tick(1);
        chk("alu_ret12", retired_a, 32'd3);
        chk("alu_x2", dut_a.regs[2], 32'hFFFF_FFFE);
        chk("alu_x3", dut_a.regs[3], 32'd7);
        tick(33);
        chk("wrap_45", {28'b0, retired_b}, 32'd15);
        tick(2);
        chk("wrap_47", {28'b0, retired_b}, 32'd15);
        tick(1);
        chk("wrap_48", {28'b0, retired_b}, 32'd0);
        chk("zero_halted", {31'b0, halted_a}, 32'd1);
        chk("zero_err", {30'b0, err_a}, 32'd1);
        chk("zero_ret", retired_a, 32'd3);
        chk("zero_pc", pc_a, 32'h10);

        // sw/lw with 3 wait cycles on every transfer
        hold();
        wait_n[0] = 3;
        mem[0][0] = 32'h0050_0093;   // addi x1,x0,5
        mem[0][1] = 32'h0410_2023;   // sw x1,64(x0)
        mem[0][2] = 32'h0400_2203;   // lw x4,64(x0)
        release_rst();
        tick(7);
        chk("ls_ret7", retired_a, 32'd1);
        tick(10);
        chk("ls_ret17", retired_a, 32'd2);
        chk("ls_memw", mem[0][16], 32'd5);
        tick(10);
        chk("ls_ret27", retired_a, 32'd2);
        tick(1);
        chk("ls_ret28", retired_a, 32'd3);
        chk("ls_x4", dut_a.regs[4], 32'd5);
        chk("ls_stable", unstable, 32'd0);
        wait_n[0] = 0;

        // beq x0,x0,-4 at 0x10 loops back to 0x0C
        hold();
        for (int i = 0; i < 4; i++) mem[0][i] = 32'h0000_0013;
        mem[0][4] = 32'hFE00_0EE3;
        release_rst();
        tick(40);
        for (int i = 3; i < 9; i++)
            chk($sformatf("beq_fetch%0d", i), flog[i], (i % 2 == 1) ? 32'h0C : 32'h10);

        // jal x0,+32 then jal x1,+16 at 0x20
        hold();
        mem[0][0] = 32'h0200_006F;
        mem[0][8] = 32'h0100_00EF;
        mem[0][12] = 32'h0000_0063;
        release_rst();
        tick(8);
        chk("jal_ret", retired_a, 32'd2);
        chk("jal_x1", dut_a.regs[1], 32'h24);
        chk("jal_pc", pc_a, 32'h30);
        chk("jal_addr", addr_a, 32'h30);

        // lui, slt/sltu on a negative operand, xori, taken blt
        hold();
        mem[0][0] = 32'h0050_0093;   // addi x1,x0,5
        mem[0][1] = 32'h8000_02B7;   // lui  x5,0x80000
        mem[0][2] = 32'h0012_A333;   // slt  x6,x5,x1
        mem[0][3] = 32'h0012_B3B3;   // sltu x7,x5,x1
        mem[0][4] = 32'hFFF0_C413;   // xori x8,x1,-1
        mem[0][5] = 32'h0012_C463;   // blt  x5,x1,+8
        mem[0][6] = 32'h0010_0493;   // addi x9,x0,1 (skipped)
        mem[0][7] = 32'h0000_0063;   // beq  x0,x0,0
        release_rst();
        tick(23);
        chk("mix_ret", retired_a, 32'd6);
        chk("mix_pc", pc_a, 32'h1C);
        chk("mix_x5", dut_a.regs[5], 32'h8000_0000);
        chk("mix_x6", dut_a.regs[6], 32'd1);
        chk("mix_x7", dut_a.regs[7], 32'd0);
        chk("mix_x8", dut_a.regs[8], 32'hFFFF_FFFA);

        // misaligned lw halts before any data transfer
        hold();
        mem[0][0] = 32'h0090_0293;   // addi x5,x0,9
        mem[0][1] = 32'h0020_2283;   // lw x5,2(x0)
        release_rst();
        tick(20);
        chk("mis_halted", {31'b0, halted_a}, 32'd1);
        chk("mis_err", {30'b0, err_a}, 32'd2);
        chk("mis_x5", dut_a.regs[5], 32'd9);
        chk("mis_ret", retired_a, 32'd1);
        chk("mis_pc", pc_a, 32'h8);
        chk("mis_ntx", ntx, 32'd2);
        chk("mis_req", {31'b0, req_a}, 32'd0);

        // add x17,x1,x2: legal on RV32I, illegal on RV32E
        hold();
        mem[0][0] = 32'h0050_0093; mem[1][0] = 32'h0050_0093;   // addi x1,x0,5
        mem[0][1] = 32'h0030_0113; mem[1][1] = 32'h0030_0113;   // addi x2,x0,3
        mem[0][2] = 32'h0020_88B3; mem[1][2] = 32'h0020_88B3;   // add x17,x1,x2
        release_rst();
        tick(12);
        chk("r32_x17", dut_a.regs[17], 32'd8);
        chk("r32_ret", retired_a, 32'd3);
        chk("r16_halted", {31'b0, halted_b}, 32'd1);
        chk("r16_err", {30'b0, err_b}, 32'd1);
        chk("r16_ret", {28'b0, retired_b}, 32'd2);

        // ebreak
        hold();
        mem[0][0] = 32'h0010_0073;
        release_rst();
        tick(5);
        chk("ebrk_halted", {31'b0, halted_a}, 32'd1);
        chk("ebrk_err", {30'b0, err_a}, 32'd3);
        chk("ebrk_ret", retired_a, 32'd0);

        // reset asserted during a stalled fetch
        hold();
        mem[0][0] = 32'h0050_0093;
        mem[0][1] = 32'h8000_02B7;
        mem[0][2] = 32'h0012_A333;
        release_rst();
        tick(8);
        wait_n[0] = 100;
        tick(3);
        chk("stall_req", {31'b0, req_a}, 32'd1);
        chk("stall_addr", addr_a, 32'h8);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", {31'b0, req_a}, 32'd0);
        chk("arst_pc", pc_a, 32'h0);
        chk("arst_ret", retired_a, 32'd0);
        wait_n[0] = 0;
        release_rst();
        tick(1);
        chk("arst_nlog", nlog, 32'd1);
        chk("arst_fetch", flog[0], 32'h0);

        chk("ret_step", step_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
